// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and bus-level constants for the I2C target
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT
  } i2c_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

endpackage

// File: rtl/i2c_target_sync_if.sv
// rtl/i2c_target_sync_if.sv - register-map port between the I2C target and the register file
interface i2c_target_sync_if #(
  parameter int REG_AW = 8
) ();

  logic [REG_AW-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_wr;
  logic              reg_rd;
  logic [7:0]        reg_rdata;

  modport master (
    output reg_addr, reg_wdata, reg_wr, reg_rd,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_wr, reg_rd,
    output reg_rdata
  );

endinterface

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - pad synchroniser, FILTER_LEN-sample debouncer and edge pulses
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Lines reset to 1 so an idle bus never produces a false edge out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt   <= 1'b1;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (synced == filt) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        cnt_q <= '0;
        filt  <= synced;
        rise  <= synced;
        fall  <= ~synced;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_target_sync.sv
// rtl/i2c_target_sync.sv - oversampled I2C target with auto-incrementing register pointer
// Define I2C_GENERAL_CALL_EN to ACK general-call (address 0x00, write) transfers.
module i2c_target_sync #(
  parameter int REG_AW      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [6:0] slv_addr_in,
  output logic       busy,
  i2c_target_sync_if.master reg_if
);

  import i2c_pkg::*;

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
    .clk  (clk),
    .rst  (rst),
    .raw  (scl_in),
    .filt (scl_f),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
    .clk  (clk),
    .rst  (rst),
    .raw  (sda_in),
    .filt (sda_f),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  i2c_state_e        state;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_q;
  logic [6:0]        addr_lat;
  logic              rw_q;
  logic              ack_on;
  logic              rd_wait;
  logic [REG_AW-1:0] reg_addr_q;
  logic [7:0]        reg_wdata_q;
  logic              reg_wr_q;
  logic              reg_rd_q;

  logic       start_det, stop_det;
  logic [7:0] rx_byte;
  logic       addr_ok;

  assign start_det = sda_fall & scl_f;
  assign stop_det  = sda_rise & scl_f;
  assign rx_byte   = {shift_q[6:0], sda_f};

  always_comb begin
    addr_ok = (rx_byte[7:1] == addr_lat);
`ifdef I2C_GENERAL_CALL_EN
    if (rx_byte[7:1] == 7'd0) addr_ok = (rx_byte[0] == I2C_RW_WRITE);
`endif
  end

  assign reg_if.reg_addr  = reg_addr_q;
  assign reg_if.reg_wdata = reg_wdata_q;
  assign reg_if.reg_wr    = reg_wr_q;
  assign reg_if.reg_rd    = reg_rd_q;

  // ACK states see two SCL falls: the first starts the ACK slot, the second ends it (ack_on).
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= 3'd7;
      shift_q     <= 8'd0;
      addr_lat    <= 7'd0;
      rw_q        <= I2C_RW_WRITE;
      ack_on      <= 1'b0;
      rd_wait     <= 1'b0;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= 8'd0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
    end else begin
      reg_wr_q <= 1'b0;
      reg_rd_q <= 1'b0;
      rd_wait  <= reg_rd_q;
      if (reg_wr_q) reg_addr_q <= reg_addr_q + REG_AW'(1);
      if (rd_wait)  shift_q    <= reg_if.reg_rdata;

      if (start_det) begin
        state    <= DEV_ADDR;
        bit_cnt  <= 3'd7;
        addr_lat <= slv_addr_in;
        busy     <= 1'b1;
        sda_oe   <= 1'b0;
        ack_on   <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        ack_on <= 1'b0;
      end else begin
        case (state)
          DEV_ADDR, PTR, WR_DATA: begin
            if (scl_rise) begin
              shift_q <= rx_byte;
              if (bit_cnt == 3'd0) begin
                bit_cnt <= 3'd7;
                ack_on  <= 1'b0;
                if (state == DEV_ADDR) begin
                  rw_q  <= rx_byte[0];
                  state <= addr_ok ? ADDR_ACK : WAIT;
                end else if (state == PTR) begin
                  reg_addr_q <= rx_byte[REG_AW-1:0];
                  state      <= PTR_ACK;
                end else begin
                  reg_wdata_q <= rx_byte;
                  reg_wr_q    <= 1'b1;
                  state       <= WR_ACK;
                end
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b1;
                ack_on <= 1'b1;
              end else begin
                ack_on  <= 1'b0;
                bit_cnt <= 3'd7;
                if (rw_q == I2C_RW_READ) begin
                  sda_oe <= ~shift_q[7];
                  state  <= RD_DATA;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= PTR;
                end
              end
            end else if (scl_rise && ack_on && rw_q == I2C_RW_READ) begin
              reg_rd_q <= 1'b1;
            end
          end
          PTR_ACK, WR_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b1;
                ack_on <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                ack_on  <= 1'b0;
                bit_cnt <= 3'd7;
                state   <= WR_DATA;
              end
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              shift_q <= {shift_q[6:0], 1'b0};
              sda_oe  <= ~shift_q[6];
            end else if (scl_rise) begin
              if (bit_cnt == 3'd0) begin
                bit_cnt <= 3'd7;
                ack_on  <= 1'b0;
                state   <= RD_ACK;
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b0;
                ack_on <= 1'b1;
              end else begin
                ack_on  <= 1'b0;
                bit_cnt <= 3'd7;
                sda_oe  <= ~shift_q[7];
                state   <= RD_DATA;
              end
            end else if (scl_rise && ack_on) begin
              if (sda_f == I2C_ACK) begin
                reg_addr_q <= reg_addr_q + REG_AW'(1);
                reg_rd_q   <= 1'b1;
              end else begin
                ack_on <= 1'b0;
                state  <= WAIT;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_sync.sv
// tb/tb_i2c_target_sync.sv - directed, table-driven bench for i2c_target_sync
module tb_i2c_target_sync;

  localparam int QCLK = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe;
  logic       busy;
  logic       sda_bus;
  logic [6:0] slv_addr = 7'h2D;

  i2c_target_sync_if #(.REG_AW(8)) reg_if ();

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target_sync #(.REG_AW(8), .SYNC_STAGES(2), .FILTER_LEN(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .scl_in      (scl_m),
    .sda_in      (sda_bus),
    .sda_oe      (sda_oe),
    .slv_addr_in (slv_addr),
    .busy        (busy),
    .reg_if      (reg_if.master)
  );

  always #5 clk = ~clk;

  // Register map: read data is addr ^ 0x55, one clock after reg_rd.
  always @(posedge clk) if (reg_if.reg_rd) reg_if.reg_rdata <= reg_if.reg_addr ^ 8'h55;

  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t wr_log[$];
  wr_t wr_e;
  int  rd_cnt = 0;

  always @(negedge clk) begin
    if (reg_if.reg_wr) begin
      wr_e.a = reg_if.reg_addr;
      wr_e.d = reg_if.reg_wdata;
      wr_log.push_back(wr_e);
    end
    if (reg_if.reg_rd) rd_cnt++;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic q();
    repeat (QCLK) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    sda_m = 1'b0; q();
    scl_m = 1'b0; q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; q();
    scl_m = 1'b1; q();
    sda_m = 1'b1; q();
  endtask

  // g: 0 none, 1 SCL high pulse in low phase, 2 SCL low pulse in high phase, 3 SDA pulse while SCL high
  task automatic send_bit(input logic b, input int g);
    sda_m = b; q();
    if (g == 1) begin scl_m = 1'b1; @(negedge clk); scl_m = 1'b0; q(); end
    scl_m = 1'b1; q();
    if (g == 2) begin scl_m = 1'b0; @(negedge clk); scl_m = 1'b1; q(); end
    if (g == 3) begin sda_m = ~b; @(negedge clk); sda_m = b; q(); end
    q();
    scl_m = 1'b0; q();
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    b = sda_bus; q();
    scl_m = 1'b0; q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i], 0);
    recv_bit(ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) recv_bit(b[i]);
    send_bit(mack, 0);
  endtask

  typedef struct {
    logic [7:0] dev;
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       ack;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] end_addr;
  } wvec_t;

  wvec_t vt[5];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic       a;
    logic [7:0] rb;
    int         wr_base, rd_base;
    int         gsel;
    logic [7:0] gbyte;

    vt[0] = '{8'h5A, 8'h10, 8'hAB, 8'hCD, 1'b1, 8'h10, 8'h11, 8'h12};
    vt[1] = '{8'h5A, 8'hFF, 8'h11, 8'h22, 1'b1, 8'hFF, 8'h00, 8'h01};
    vt[2] = '{8'h60, 8'h33, 8'h44, 8'h55, 1'b0, 8'h00, 8'h00, 8'h01};
`ifdef I2C_GENERAL_CALL_EN
    vt[3] = '{8'h00, 8'h3C, 8'h66, 8'h77, 1'b1, 8'h3C, 8'h3D, 8'h3E};
`else
    vt[3] = '{8'h00, 8'h3C, 8'h66, 8'h77, 1'b0, 8'h00, 8'h00, 8'h01};
`endif
    vt[4] = '{8'h5A, 8'h7E, 8'h01, 8'h02, 1'b1, 8'h7E, 8'h7F, 8'h80};

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_reg_addr", reg_if.reg_addr, 0);
    chk("rst_reg_wdata", reg_if.reg_wdata, 0);
    chk("rst_reg_wr", reg_if.reg_wr, 0);
    chk("rst_reg_rd", reg_if.reg_rd, 0);
    chk("rst_busy", busy, 0);
    q();

    for (int i = 0; i < 5; i++) begin
      wr_base = wr_log.size();
      rd_base = rd_cnt;
      bus_start();
      write_byte(vt[i].dev, a); chk($sformatf("v%0d_dev_ack", i), a, vt[i].ack ? 0 : 1);
      write_byte(vt[i].ptr, a); chk($sformatf("v%0d_ptr_ack", i), a, vt[i].ack ? 0 : 1);
      write_byte(vt[i].d0, a);  chk($sformatf("v%0d_d0_ack", i), a, vt[i].ack ? 0 : 1);
      write_byte(vt[i].d1, a);  chk($sformatf("v%0d_d1_ack", i), a, vt[i].ack ? 0 : 1);
      chk($sformatf("v%0d_busy_mid", i), busy, 1);
      bus_stop(); q();
      chk($sformatf("v%0d_busy_end", i), busy, 0);
      chk($sformatf("v%0d_wr_cnt", i), wr_log.size() - wr_base, vt[i].ack ? 2 : 0);
      if (wr_log.size() - wr_base == 2 && vt[i].ack) begin
        chk($sformatf("v%0d_wa0", i), wr_log[wr_base].a, vt[i].a0);
        chk($sformatf("v%0d_wd0", i), wr_log[wr_base].d, vt[i].d0);
        chk($sformatf("v%0d_wa1", i), wr_log[wr_base+1].a, vt[i].a1);
        chk($sformatf("v%0d_wd1", i), wr_log[wr_base+1].d, vt[i].d1);
      end
      chk($sformatf("v%0d_end_addr", i), reg_if.reg_addr, vt[i].end_addr);
      chk($sformatf("v%0d_rd_cnt", i), rd_cnt - rd_base, 0);
    end

    // Pointer write, repeated START, 3-byte read ACK/ACK/NACK.
    wr_base = wr_log.size();
    rd_base = rd_cnt;
    bus_start();
    write_byte(8'h5A, a); chk("rd_dev_w_ack", a, 0);
    write_byte(8'h20, a); chk("rd_ptr_ack", a, 0);
    bus_start();
    write_byte(8'h5B, a); chk("rd_dev_r_ack", a, 0);
    read_byte(1'b0, rb); chk("rd_byte0", rb, 8'h75);
    read_byte(1'b0, rb); chk("rd_byte1", rb, 8'h74);
    read_byte(1'b1, rb); chk("rd_byte2", rb, 8'h77);
    chk("rd_busy_mid", busy, 1);
    chk("rd_oe_after_nack", sda_oe, 0);
    bus_stop(); q();
    chk("rd_busy_end", busy, 0);
    chk("rd_rd_cnt", rd_cnt - rd_base, 3);
    chk("rd_wr_cnt", wr_log.size() - wr_base, 0);
    chk("rd_end_addr", reg_if.reg_addr, 8'h22);

    // Sub-FILTER_LEN glitches inside a data byte.
    wr_base = wr_log.size();
    bus_start();
    write_byte(8'h5A, a); chk("gl_dev_ack", a, 0);
    write_byte(8'h40, a); chk("gl_ptr_ack", a, 0);
    gbyte = 8'h96;
    for (int i = 7; i >= 0; i--) begin
      gsel = (i == 6) ? 1 : (i == 4) ? 2 : (i == 2) ? 3 : 0;
      send_bit(gbyte[i], gsel);
    end
    recv_bit(a); chk("gl_data_ack", a, 0);
    chk("gl_busy_mid", busy, 1);
    bus_stop(); q();
    chk("gl_wr_cnt", wr_log.size() - wr_base, 1);
    if (wr_log.size() - wr_base == 1) begin
      chk("gl_wa", wr_log[wr_base].a, 8'h40);
      chk("gl_wd", wr_log[wr_base].d, 8'h96);
    end
    chk("gl_end_addr", reg_if.reg_addr, 8'h41);

    // Reset while driving a read 0 bit (0x41^0x55 = 0x14, MSB 0).
    bus_start();
    write_byte(8'h5B, a); chk("rs_dev_ack", a, 0);
    chk("rs_pre_oe", sda_oe, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rs_oe_next_clk", sda_oe, 0);
    chk("rs_busy", busy, 0);
    chk("rs_reg_addr", reg_if.reg_addr, 0);
    wr_base = wr_log.size();
    rd_base = rd_cnt;
    for (int i = 0; i < 4; i++) send_bit(1'b0, 0);
    chk("rs_ignored_oe", sda_oe, 0);
    chk("rs_ignored_busy", busy, 0);
    chk("rs_ignored_rd", rd_cnt - rd_base, 0);
    bus_start();
    write_byte(8'h5A, a); chk("rs_new_dev_ack", a, 0);
    write_byte(8'h05, a); chk("rs_new_ptr_ack", a, 0);
    write_byte(8'h99, a); chk("rs_new_d_ack", a, 0);
    bus_stop(); q();
    chk("rs_new_wr_cnt", wr_log.size() - wr_base, 1);
    if (wr_log.size() - wr_base == 1) begin
      chk("rs_new_wa", wr_log[wr_base].a, 8'h05);
      chk("rs_new_wd", wr_log[wr_base].d, 8'h99);
    end
    chk("rs_new_end_addr", reg_if.reg_addr, 8'h06);
    chk("rs_new_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/i2c_target_sync.md
Name: i2c_target_sync

Overview:
Second-generation I2C target: SCL/SDA are oversampled on the system clock, not used as clocks. It synchronises and glitch-filters the bus, detects START, repeated START and STOP, and runs a register-pointer protocol with multi-byte auto-increment reads and writes. It sits between the chip pads (open-drain SDA) and the on-chip register map, replacing the SCL-clocked target.

Parameters:
REG_AW, 8, register address/pointer width in bits (1..8; pointer byte truncated to REG_AW LSBs)
SYNC_STAGES, 2, flip-flop synchroniser depth on scl_in/sda_in (>=2)
FILTER_LEN, 3, consecutive identical synchronised samples required before filtered line changes (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-high
scl_in  in  1  raw SCL pad input
sda_in  in  1  raw SDA pad input
sda_oe  out  1  1 = drive SDA low, 0 = release
slv_addr_in  in  7  target address, sampled at every START
reg_addr  out  REG_AW  current register pointer
reg_wdata  out  8  write data to register map
reg_wr  out  1  one-clk write strobe
reg_rd  out  1  one-clk read request
reg_rdata  in  8  read data, valid exactly 1 clk after reg_rd
busy  out  1  high from START until STOP/IDLE

Behaviour:
- Reset: sda_oe=0, reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, busy=0, state IDLE, filters preset to 1 (bus idle), bit counter=7.
- Filter: scl_f/sda_f change only after FILTER_LEN equal synchronised samples; scl_rise/scl_fall are 1-clk pulses on scl_f edges.
- START = sda_f falls while scl_f high; STOP = sda_f rises while scl_f high. START from any state -> DEV_ADDR, counter=7, latch slv_addr_in, busy=1. STOP from any state -> IDLE, sda_oe=0, busy=0. Both have priority over bit handling in the same clk.
- SDA sampled on scl_rise; sda_oe changes only on scl_fall (never while SCL high).
- States: IDLE, DEV_ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT.
- DEV_ADDR: shift 8 bits MSB first. After 8th rise: match addr[7:1]==latched address -> ADDR_ACK (sda_oe=1 on next fall); mismatch -> WAIT with SDA released (NACK).
- ADDR_ACK, R/W=0 -> PTR; R/W=1 -> reg_rd pulses on the ACK-bit scl_rise, reg_rdata captured next clk into shift register, MSB driven at ACK-ending scl_fall -> RD_DATA.
- PTR: 8 bits -> reg_addr <= byte[REG_AW-1:0], ACK -> WR_DATA.
- WR_DATA: 8 bits -> reg_wdata=byte, reg_wr pulses the clk after the 8th rise at current reg_addr; ACK; reg_addr increments after the strobe, wrapping 2^REG_AW-1 -> 0.
- RD_DATA: drive 8 bits (sda_oe = ~bit). RD_ACK: release SDA, sample master ACK; ACK(0) -> reg_addr+1 (wrap), reg_rd, reload, continue; NACK(1) -> WAIT.
- WAIT: SDA released, ignores bits until START/STOP.
- reg_addr retained across repeated START and STOP (write-pointer then repeated-START read works).
- Counter underflow: 7..0 then reload 7 at each ACK phase.
- Synchronous rst mid-transfer: SDA released next clk, state IDLE; following bus activity ignored until a fresh START.

Optional Feature:
I2C_GENERAL_CALL_EN: defined -> address byte 0x00 (write) is ACKed and treated as a normal write with pointer; 0x01 NACKed. Undefined -> address 0x00 NACKed unless slv_addr_in==0.

Decomposition:
- Package i2c_pkg: state enum, I2C_RW_READ/I2C_RW_WRITE constants, ACK/NACK levels.
- Sub-module i2c_line_filter (synchroniser + FILTER_LEN debouncer + edge pulses), instantiated twice.

Test Plan:
- Write 0x5A,0x10,0xAB,0xCD (slv_addr_in=0x2D) -> ACK on all 4; reg_wr twice: (0x10,0xAB),(0x11,0xCD); reg_addr=0x12 after.
- Write ptr 0xFF then 2 data bytes, REG_AW=8 -> writes at 0xFF then 0x00 (wrap).
- Write ptr 0x20, repeated START, read 0x5B, 3 bytes ACK,ACK,NACK with map returning addr^0x55 -> SDA carries 0x75,0x74,0x77; STOP -> busy=0.
- Address 0x60 -> SDA released in ACK slot, no reg_wr/reg_rd, WAIT until STOP.
- 1-clk SCL glitches (< FILTER_LEN) injected mid-byte -> data unchanged, no spurious START/STOP.
- rst during RD_DATA with sda_oe=1 -> sda_oe=0 next clk, IDLE; next full transaction succeeds.
